draw_text_line: RTL and testbench

//  Reader side of the filter-name text ROM. Walks a fixed text box on the VGA raster
//  and issues char_xy to the text ROM, which returns char_code. Issues font row

---
 rtl/draw_text_line.sv | 91 +++++++++
 tb/tb_draw_text_line.sv | 135 +++++++++++++
 2 files changed

// File: rtl/draw_text_line.sv
// draw_text_line: walks a fixed text box on the raster, addresses text/font ROMs and overlays glyph pixels on rgb.
module draw_text_line #(
  parameter int XPOS = 100,
  parameter int YPOS = 50,
  parameter int CHARS = 30,
  parameter logic [11:0] TEXT_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [3:0]  sw_in,
  output logic [3:0]  sw_out,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam logic [11:0] X0 = 12'(XPOS);
  localparam logic [11:0] Y0 = 12'(YPOS);
  localparam logic [11:0] W = 12'(8 * CHARS);
  logic [11:0] dx, dy;
  logic        in_box;
  logic [37:0] s1_d, s1_q, s2_d, s2_q, out_d, out_q;
  logic        box1_d, box1_q, box2_d, box2_q;
  logic [2:0]  col1_d, col1_q, col2_d, col2_q;
  logic [7:0]  xy_d, xy_q;
  logic [3:0]  line_d, line_q, sw_d, sw_q;
  logic        vb_d, vb_q;
  logic        pix;
  // Offsets wrap to large values left of / above the box, so one unsigned compare bounds each axis.
  always_comb begin
    dx = {1'b0, hcount_in} - X0;
    dy = {1'b0, vcount_in} - Y0;
    in_box = (dx < W) && (dy < 12'd16);
    s1_d = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    box1_d = in_box;
    col1_d = dx[2:0];
    xy_d = in_box ? dx[10:3] : 8'd0;
    line_d = in_box ? dy[3:0] : 4'd0;
    s2_d = s1_q;
    box2_d = box1_q;
    col2_d = col1_q;
    pix = char_pixels[3'd7 - col2_q];
    out_d = {s2_q[37:12], (s2_q[13] | s2_q[12]) ? 12'h000 : (box2_q && pix) ? TEXT_COLOR : s2_q[11:0]};
    vb_d = vblnk_in;
    sw_d = (vblnk_in && !vb_q) ? sw_in : sw_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      out_q <= '0;
      box1_q <= 1'b0;
      box2_q <= 1'b0;
      col1_q <= '0;
      col2_q <= '0;
      xy_q <= '0;
      line_q <= '0;
      sw_q <= '0;
      vb_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      out_q <= out_d;
      box1_q <= box1_d;
      box2_q <= box2_d;
      col1_q <= col1_d;
      col2_q <= col2_d;
      xy_q <= xy_d;
      line_q <= line_d;
      sw_q <= sw_d;
      vb_q <= vb_d;
    end
  end
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} = out_q;
  assign char_xy = xy_q;
  assign char_line = line_q;
  assign sw_out = sw_q;
endmodule

// File: tb/tb_draw_text_line.sv
// tb_draw_text_line: random and directed raster stimulus against a per-pixel reference model of the text overlay.
module tb_draw_text_line;
  logic        clk, rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic [3:0]  sw_in, sw_out, char_line;
  logic [7:0]  char_xy, char_pixels;
  int checks = 0, failures = 0;
  typedef struct {
    logic [37:0] tim;
    logic [7:0]  xy;
    logic [3:0]  ln;
  } exp_t;
  exp_t q[$];
  logic [3:0] sw_exp;
  logic       prev_vb;
  logic       vb_state;

  draw_text_line dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .sw_in(sw_in), .sw_out(sw_out), .char_xy(char_xy), .char_line(char_line),
    .char_pixels(char_pixels), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [7:0] xy, input logic [3:0] ln);
    if (xy == 8'd2 && ln == 4'd5) return 8'b0001_0000;
    return 8'((xy * 29) ^ ({ln, ln} + 8'h5A));
  endfunction

  always @(posedge clk) char_pixels <= glyph(char_xy, char_line);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: checks what the previous rising edges produced, then drives the next pixel.
  task automatic apply(input int h, input int v, input logic hs, input logic vs, input logic hb,
                       input logic vb, input logic [11:0] rgb, input logic [3:0] sw);
    exp_t e;
    bit inbox, pix;
    int xy, ln, col;
    if (q.size() == 3) begin
      e = q.pop_front();
      check("timing_rgb", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}, e.tim);
    end
    if (q.size() > 0) begin
      check("char_xy", char_xy, q[$].xy);
      check("char_line", char_line, q[$].ln);
    end
    check("sw_out", sw_out, sw_exp);
    hcount_in = 11'(h); vcount_in = 11'(v); hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb; sw_in = sw;
    inbox = (h >= 100) && (h < 340) && (v >= 50) && (v < 66);
    xy = inbox ? (h - 100) / 8 : 0;
    ln = inbox ? v - 50 : 0;
    col = (h - 100) % 8;
    pix = inbox && glyph(8'(xy), 4'(ln))[7 - col];
    e.xy = 8'(xy);
    e.ln = 4'(ln);
    e.tim = {11'(h), 11'(v), hs, vs, hb, vb, (hb || vb) ? 12'h000 : pix ? 12'hFFF : rgb};
    q.push_back(e);
    if (vb && !prev_vb) sw_exp = sw;
    prev_vb = vb;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {sw_out, char_xy, char_line, hcount_out, vcount_out, hsync_out, vsync_out,
                hblnk_out, vblnk_out, rgb_out}, 64'd0);
  endtask

  task automatic mid_reset();
    rgb_in = 12'hABC;
    #2 rst = 1;
    #1 check_zero("reset_immediate");
    @(negedge clk);
    check_zero("reset_held");
    rst = 0;
    q.delete();
    sw_exp = 0;
    prev_vb = 0;
  endtask

  initial begin
    rst = 1; hcount_in = 0; vcount_in = 0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = 0; sw_in = 0;
    sw_exp = 0; prev_vb = 0; vb_state = 0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_initial");
    rst = 0;
    apply(5, 5, 1, 0, 0, 0, 12'h123, 0);
    apply(5, 5, 0, 0, 0, 0, 12'h456, 0);
    apply(119, 55, 0, 0, 0, 0, 12'h321, 0);
    apply(118, 55, 0, 0, 0, 0, 12'h654, 0);
    apply(99, 55, 0, 0, 0, 0, 12'h111, 0);
    apply(340, 55, 0, 0, 0, 0, 12'h222, 0);
    apply(339, 55, 0, 0, 0, 0, 12'h333, 0);
    apply(120, 49, 0, 0, 0, 0, 12'h444, 0);
    apply(120, 66, 0, 0, 0, 0, 12'h555, 0);
    apply(100, 50, 0, 0, 0, 0, 12'h666, 0);
    apply(119, 55, 0, 0, 1, 0, 12'h777, 0);
    apply(119, 55, 0, 0, 0, 1, 12'h888, 0);
    apply(119, 55, 0, 0, 0, 0, 12'h999, 3);
    for (int i = 0; i < 4; i++) apply(200, 60, 0, 0, 0, 0, 12'h0F0, 3);
    apply(200, 60, 0, 1, 0, 1, 12'h0F0, 3);
    apply(200, 60, 0, 1, 0, 1, 12'h0F0, 5);
    apply(200, 60, 0, 0, 0, 1, 12'h0F0, 9);
    apply(200, 60, 0, 0, 0, 0, 12'h0F0, 9);
    for (int i = 0; i < 3; i++) apply(200, 60, 0, 0, 0, 0, 12'h0F0, 9);
    mid_reset();
    for (int i = 0; i < 4; i++) apply(5, 5, 0, 0, 0, 0, 12'hABC, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) vb_state = ~vb_state;
      apply(90 + $urandom_range(0, 260), 45 + $urandom_range(0, 25), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, vb_state, 12'($urandom), 4'($urandom));
    end
    mid_reset();
    for (int i = 0; i < 5; i++) apply(150, 52, 0, 0, 0, 0, 12'h5A5, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
